// File: rtl/heading_pid_pkg.sv
// Shared constants and the signed-narrowing helper for the heading-hold PID.
package heading_pid_pkg;

  localparam int HDG_W     = 12;
  localparam int ERR_W     = 10;
  localparam int DIFF_W    = 8;
  localparam int INTG_W    = 16;
  localparam int SPD_W     = 12;
  localparam int FRWRD_W   = 11;
  localparam int P_W       = 14;
  localparam int D_W       = 13;
  localparam int SUM_W     = 15;
  localparam int PID_SHIFT = 3;

  localparam logic signed [3:0] P_COEFF = 4'sd3;
  localparam logic signed [4:0] D_COEFF = 5'sd7;
  localparam int AT_HDG_THRESH = 30;

  // Clamp a signed value to the range of a w-bit two's complement number.
  // Callers narrow the result with a size cast to the target width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                     input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pid_intgrtr.sv
// Integral accumulator: adds the saturated heading error on each enabled
// update, refuses any update that would overflow (holds instead of wrapping),
// and clears synchronously whenever the robot is not moving.
module pid_intgrtr
  import heading_pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ERR_W-1:0]  inc,
  output logic signed [INTG_W-1:0] value
);

  logic signed [INTG_W:0] sum;
  logic                   ovf;

  // One extra bit of headroom exposes a signed overflow as a sign mismatch.
  always_comb begin
    sum = (INTG_W + 1)'(value) + (INTG_W + 1)'(inc);
    ovf = sum[INTG_W] != sum[INTG_W-1];
  end

  // Clear has priority over an update arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en && !ovf) begin
      value <= sum[INTG_W-1:0];
    end
  end

endmodule

// File: rtl/heading_pid.sv
// Heading-hold PID: turns each new heading sample into differential wheel
// speed demands through a 3-stage pipeline (error, P/I/D terms, mix).
module heading_pid
  import heading_pid_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int D_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hdg_vld,
  input  logic signed [11:0] actl_hdg,
  input  logic signed [11:0] dsrd_hdg,
  input  logic               moving,
  input  logic [10:0]        frwrd,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               spd_vld,
  output logic               at_hdg
);

  localparam int I_SHIFT = (FAST_SIM != 0) ? 1 : 4;

  logic signed [HDG_W-1:0]  err_c;
  logic signed [ERR_W-1:0]  err_sat_c;
  logic                     at_hdg_c;
  logic signed [ERR_W-1:0]  err_p1;
  logic                     vld_p1;

  logic signed [DIFF_W-1:0] d_diff_c;
  logic signed [P_W-1:0]    p_c;
  logic signed [D_W-1:0]    d_c;
  logic signed [P_W-1:0]    p_p2;
  logic signed [D_W-1:0]    d_p2;
  logic                     vld_p2;
  logic signed [ERR_W-1:0]  dq [D_DEPTH];
  logic signed [INTG_W-1:0] intg;

  logic signed [SPD_W-1:0]  i_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SPD_W-1:0]  pid_c;
  logic signed [SPD_W-1:0]  lft_c;
  logic signed [SPD_W-1:0]  rght_c;

  // ---- stage 1: heading error (wraps modulo 4096), saturation, at-heading
  always_comb begin
    err_c     = actl_hdg - dsrd_hdg;
    err_sat_c = ERR_W'(sat_signed(32'(err_c), ERR_W));
    at_hdg_c  = (32'(err_sat_c) < AT_HDG_THRESH) && (32'(err_sat_c) > -AT_HDG_THRESH);
  end

  // Register the error and the at-heading flag only when a new sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= '0;
      at_hdg <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= hdg_vld;
      if (hdg_vld) begin
        err_p1 <= err_sat_c;
        at_hdg <= at_hdg_c;
      end
    end
  end

  // ---- stage 2: proportional and derivative terms, past-error queue
  always_comb begin
    d_diff_c = DIFF_W'(sat_signed(32'(err_p1) - 32'(dq[D_DEPTH-1]), DIFF_W));
    p_c      = P_W'(32'(err_p1) * 32'(P_COEFF));
    d_c      = D_W'(32'(d_diff_c) * 32'(D_COEFF));
  end

  // P/D terms follow the sample; the queue empties whenever the robot stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p2   <= '0;
      d_p2   <= '0;
      vld_p2 <= 1'b0;
      for (int i = 0; i < D_DEPTH; i++) dq[i] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        p_p2 <= p_c;
        d_p2 <= d_c;
      end
      if (!moving) begin
        for (int i = 0; i < D_DEPTH; i++) dq[i] <= '0;
      end else if (vld_p1) begin
        for (int i = D_DEPTH - 1; i > 0; i--) dq[i] <= dq[i-1];
        dq[0] <= err_p1;
      end
    end
  end

  pid_intgrtr u_intg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!moving),
    .en    (vld_p1),
    .inc   (err_p1),
    .value (intg)
  );

  // ---- stage 3: integral scaling, term sum, differential wheel mix
  always_comb begin
    i_c    = SPD_W'(sat_signed(32'(intg) >>> I_SHIFT, SPD_W));
    sum_c  = SUM_W'(32'(p_p2) + 32'(i_c) + 32'(d_p2));
    pid_c  = SPD_W'(sum_c >>> PID_SHIFT);
    lft_c  = SPD_W'(sat_signed($signed(32'(frwrd)) + 32'(pid_c), SPD_W));
    rght_c = SPD_W'(sat_signed($signed(32'(frwrd)) - 32'(pid_c), SPD_W));
  end

  // Speeds update only with a completed sample and hold otherwise; a stopped
  // robot still reports the sample but with zero speed demands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else begin
      spd_vld <= vld_p2;
      if (vld_p2) begin
        lft_spd  <= moving ? lft_c : '0;
        rght_spd <= moving ? rght_c : '0;
      end
    end
  end

endmodule
